// File: rtl/weight_stream_ctrl_if.sv
// Bundle of the control, ROM-side and stream-side signals of weight_stream_ctrl.
// The master modport is the controller's view; slave is the environment's view.
interface weight_stream_ctrl_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 4,
  parameter int PASS_W = 8
);
  logic              start;
  logic [PASS_W-1:0] num_passes;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ce;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_ready;
  logic              data_out_last;

  modport master (
    input  start, num_passes, rom_q, data_out_ready,
    output busy, done, rom_addr, rom_ce, data_out, data_out_valid, data_out_last
  );

  modport slave (
    output start, num_passes, rom_q, data_out_ready,
    input  busy, done, rom_addr, rom_ce, data_out, data_out_valid, data_out_last
  );
endinterface

// File: rtl/weight_stream_ctrl.sv
// Streams a fixed-latency ROM as a valid/ready word stream, replaying all
// addresses num_passes times per start, with credit-based back-pressure.
module weight_stream_ctrl #(
  parameter int DATA_W  = 512,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH) + 1,
  parameter int ROM_LAT = 2,
  parameter int PASS_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  weight_stream_ctrl_if.master bus
);

  localparam int FIFO_DEPTH = ROM_LAT + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [PASS_W-1:0]   r_pass;
  logic [PASS_W-1:0]   r_num_passes;

  logic [ROM_LAT-1:0]  r_fl_vld;
  logic [ROM_LAT-1:0]  r_fl_last;

  logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [CNT_W:0] w_used;
  logic           w_issue;
  logic           w_addr_end;
  logic           w_pass_end;
  logic           w_wr;
  logic           w_valid;
  logic           w_rd;
  logic           w_final;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Slots already spoken for: words buffered plus words still inside the ROM.
  // NOTE: every variable written here gets a value before any conditional use, so no latch.
  always_comb begin
    w_used = {1'b0, r_count};
    for (int i = 0; i < ROM_LAT; i++) begin
      w_used = w_used + {{CNT_W{1'b0}}, r_fl_vld[i]};
    end
  end

  assign w_issue    = (r_state == S_RUN) && (w_used < (CNT_W+1)'(FIFO_DEPTH));
  assign w_addr_end = (r_addr == ADDR_W'(DEPTH - 1));
  assign w_pass_end = (r_pass == r_num_passes - PASS_W'(1));
  assign w_wr       = r_fl_vld[ROM_LAT-1];
  assign w_valid    = (r_count != '0);
  assign w_rd       = w_valid && bus.data_out_ready;
  assign w_final    = (r_state == S_DRAIN) && w_rd && (r_count == CNT_W'(1)) && (r_fl_vld == '0);

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.rom_ce         = r_busy;
  assign bus.rom_addr       = r_addr;
  assign bus.data_out_valid = w_valid;
  assign bus.data_out       = w_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.data_out_last  = w_valid && r_mem_last[r_rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_addr       <= '0;
      r_pass       <= '0;
      r_num_passes <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_passes != '0) begin
              r_state      <= S_RUN;
              r_busy       <= 1'b1;
              r_num_passes <= bus.num_passes;
              r_addr       <= '0;
              r_pass       <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_addr_end) begin
              r_addr <= '0;
              if (w_pass_end) r_state <= S_DRAIN;
              else            r_pass  <= r_pass + 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_final) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tracks which ROM pipeline slots carry a real read and whether it ends a pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fl_vld  <= '0;
      r_fl_last <= '0;
    end else begin
      for (int i = ROM_LAT - 1; i > 0; i--) begin
        r_fl_vld[i]  <= r_fl_vld[i-1];
        r_fl_last[i] <= r_fl_last[i-1];
      end
      r_fl_vld[0]  <= w_issue;
      r_fl_last[0] <= w_issue && w_addr_end;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; an empty FIFO presents zeros instead.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr]      <= bus.rom_q;
      r_mem_last[r_wr_ptr] <= r_fl_last[ROM_LAT-1];
    end
  end

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Self-checking bench for weight_stream_ctrl: a 2-cycle ROM model feeds the
// DUT and every handshaked word is compared with the expected pass sequence.
module tb_weight_stream_ctrl;

  localparam int DATA_W     = 512;
  localparam int DEPTH      = 8;
  localparam int AW         = $clog2(DEPTH);
  localparam int ADDR_W     = AW + 1;
  localparam int ROM_LAT    = 2;
  localparam int PASS_W     = 8;
  localparam int FIFO_DEPTH = ROM_LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_stream_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PASS_W(PASS_W)) bus ();

  weight_stream_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .PASS_W(PASS_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: two registered stages, both gated by ce.
  logic [DATA_W-1:0] rom_mem [DEPTH];
  logic [DATA_W-1:0] rom_s1;
  always @(posedge clk) begin
    if (bus.rom_ce) begin
      rom_s1    <= rom_mem[bus.rom_addr[AW-1:0]];
      bus.rom_q <= rom_s1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: expected stream plus observation bookkeeping.
  logic [DATA_W-1:0] exp_q[$];
  bit                exp_last_q[$];
  int cyc, hs_idx, issues, done_cnt, done_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc;
  logic              busy_at_done, prev_valid, prev_ready, prev_ce, prev_last;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;
  bit                ever_ce, ever_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_last_q.delete();
    cyc = 0; hs_idx = 0; issues = 0; done_cnt = 0; done_cyc = -1;
    first_valid_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
    busy_at_done = 1'bx; prev_valid = 1'b0; prev_ready = 1'b0; prev_ce = 1'b0;
    prev_last = 1'b0; prev_data = '0; prev_addr = '0;
    ever_ce = 1'b0; ever_valid = 1'b0;
  endtask

  // The stream is simply every ROM word in address order, once per pass.
  task automatic build_expect(input int npass);
    for (int p = 0; p < npass; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        exp_q.push_back(rom_mem[a]);
        exp_last_q.push_back(a == DEPTH - 1);
      end
    end
  endtask

  task automatic observe();
    if (bus.rom_ce) ever_ce = 1'b1;
    if (bus.data_out_valid) begin
      ever_valid = 1'b1;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (bus.data_out_valid && prev_valid && !prev_ready) begin
      check_w("stall_data", bus.data_out, prev_data);
      check("stall_last", 32'(bus.data_out_last), 32'(prev_last));
    end
    if (bus.rom_ce && prev_ce && bus.rom_addr != prev_addr) issues++;
    if (bus.rom_ce) check("outstanding_le_fifo", 32'((issues - hs_idx) <= FIFO_DEPTH), 32'd1);
    if (bus.done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = bus.busy;
    end
    if (bus.data_out_valid && bus.data_out_ready) begin
      if (hs_idx < exp_q.size()) begin
        check_w("word", bus.data_out, exp_q[hs_idx]);
        check("word_last", 32'(bus.data_out_last), 32'(exp_last_q[hs_idx]));
      end else begin
        check("extra_word", hs_idx, exp_q.size());
      end
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_idx++;
    end
    prev_valid = bus.data_out_valid;
    prev_ready = bus.data_out_ready;
    prev_ce    = bus.rom_ce;
    prev_data  = bus.data_out;
    prev_last  = bus.data_out_last;
    prev_addr  = bus.rom_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: ready high; 1: ready ~30% random; 2: ready low through cycle 20.
  task automatic set_ready(input int mode);
    case (mode)
      1:       bus.data_out_ready = ($urandom_range(0, 99) < 30);
      2:       bus.data_out_ready = (cyc > 20);
      default: bus.data_out_ready = 1'b1;
    endcase
  endtask

  task automatic run_job(input int npass, input int mode, input int dup_start_cyc);
    clear_model();
    build_expect(npass);
    bus.start      = 1'b1;
    bus.num_passes = PASS_W'(npass);
    set_ready(mode);
    observe();
    tick();
    for (int k = 0; k < 600 && done_cnt == 0; k++) begin
      bus.start      = (cyc == dup_start_cyc);
      bus.num_passes = 8'd5;
      set_ready(mode);
      observe();
      if (cyc == 1) begin
        check("first_busy", 32'(bus.busy), 32'd1);
        check("first_ce", 32'(bus.rom_ce), 32'd1);
        check("first_addr", 32'(bus.rom_addr), 32'd0);
      end
      if (mode == 2 && cyc == 20) begin
        check("stall_addr", 32'(bus.rom_addr), 32'd4);
        check("stall_issues", issues, FIFO_DEPTH);
        check("stall_valid", 32'(bus.data_out_valid), 32'd1);
      end
      tick();
    end
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_ready(0);
      observe();
      tick();
    end
    check("word_count", hs_idx, npass * DEPTH);
    check("done_count", done_cnt, 1);
    check("done_after_last", done_cyc, last_hs_cyc + 1);
    check("busy_at_done", 32'(busy_at_done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_valid", 32'(bus.data_out_valid), 32'd0);
    if (mode != 1) check("first_valid_cycle", first_valid_cyc, ROM_LAT + 2);
    if (mode == 0) check("no_bubbles", last_hs_cyc - first_hs_cyc, npass * DEPTH - 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_ce"}, 32'(bus.rom_ce), 32'd0);
    check({tag, "_valid"}, 32'(bus.data_out_valid), 32'd0);
    check({tag, "_last"}, 32'(bus.data_out_last), 32'd0);
    check({tag, "_addr"}, 32'(bus.rom_addr), 32'd0);
    check_w({tag, "_data"}, bus.data_out, '0);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = '0;
      w[31:0] = 32'(i + 1);
      w[DATA_W-1 -: 32] = $urandom;
      rom_mem[i] = w;
    end
    bus.start          = 1'b0;
    bus.num_passes     = '0;
    bus.data_out_ready = 1'b0;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;
    tick();

    // Single pass, full throughput.
    run_job(1, 0, -1);
    // Three passes, no bubbles across pass boundaries.
    run_job(3, 0, -1);
    // Two passes under random back-pressure.
    run_job(2, 1, -1);
    // Consumer stalled for 20 cycles: only FIFO_DEPTH reads may be issued.
    run_job(1, 2, -1);
    // A start pulse while busy must be ignored.
    run_job(1, 0, 6);

    // Zero passes: immediate done, no reads, no data.
    clear_model();
    bus.start      = 1'b1;
    bus.num_passes = '0;
    bus.data_out_ready = 1'b1;
    observe();
    tick();
    bus.start = 1'b0;
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 10; k++) begin
      observe();
      tick();
    end
    check("zero_done_count", done_cnt, 1);
    check("zero_ce", 32'(ever_ce), 32'd0);
    check("zero_valid", 32'(ever_valid), 32'd0);

    // Asynchronous reset mid-pass with valid high.
    clear_model();
    build_expect(1);
    bus.start      = 1'b1;
    bus.num_passes = 8'd1;
    bus.data_out_ready = 1'b1;
    observe();
    tick();
    bus.start = 1'b0;
    while (cyc < 6) begin
      observe();
      tick();
    end
    check("pre_reset_valid", 32'(bus.data_out_valid), 32'd1);
    #3 rst = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    tick();
    check("reset_no_done_a", 32'(bus.done), 32'd0);
    tick();
    check("reset_no_done_b", 32'(bus.done), 32'd0);
    rst = 1'b1;
    tick();
    check("post_reset_done", 32'(bus.done), 32'd0);
    run_job(1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
